// File: rtl/matmul_host_driver_if.sv
// Host/engine bus for matmul_host_driver: operand writes, result reads,
// status flags and the byte-serial engine link.
interface matmul_host_driver_if;
  logic        wr_en;
  logic [4:0]  wr_addr;
  logic [7:0]  wr_data;
  logic        go;
  logic [3:0]  rd_addr;
  logic [17:0] rd_data;
  logic        busy;
  logic        done;
  logic        err;
  logic        mm_start;
  logic [7:0]  mm_data_out;
  logic        mm_valid;
  logic        mm_done;
  logic [7:0]  mm_data_in;

  modport slave (
    input  wr_en, wr_addr, wr_data, go, rd_addr, mm_done, mm_data_in,
    output rd_data, busy, done, err, mm_start, mm_data_out, mm_valid
  );

  modport master (
    output wr_en, wr_addr, wr_data, go, rd_addr, mm_done, mm_data_in,
    input  rd_data, busy, done, err, mm_start, mm_data_out, mm_valid
  );
endinterface

// File: rtl/matmul_host_driver.sv
// Host-side driver for the 3x3 byte-serial matmul engine: streams 18 operand
// bytes, collects 27 result bytes into nine 18-bit results. Optional WAIT timeout: MMH_TIMEOUT_EN.
module matmul_host_driver #(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned TO_W           = 8
) (
  input logic                  clk,
  input logic                  rst,
  matmul_host_driver_if.slave  bus
);

  typedef enum logic [2:0] {IDLE, START, SEND, WAIT, RECV, DONE} state_t;

  localparam logic [4:0] SEND_LAST = 5'd17;
  localparam logic [4:0] RECV_LAST = 5'd26;

  if (TO_W < $clog2(TIMEOUT_CYCLES + 1)) begin : g_to_w_check
    $error("TO_W cannot hold TIMEOUT_CYCLES");
  end

  state_t      state, state_n;
  logic [4:0]  cnt;
  logic [7:0]  operand [18];
  logic [17:0] result  [9];
  logic [7:0]  op_sel;
  logic [3:0]  rx_idx;
  logic [1:0]  rx_slot;
  logic        timeout;

`ifdef MMH_TIMEOUT_EN
  logic [TO_W-1:0] to_cnt;
  logic            err_q;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    timeout = 1'b0;
    case (state)
      IDLE:  if (bus.go) state_n = START;
      START: state_n = SEND;
      SEND:  if (cnt == SEND_LAST) state_n = WAIT;
      WAIT: begin
        if (bus.mm_done) state_n = RECV;
`ifdef MMH_TIMEOUT_EN
        else if (to_cnt == TO_W'(TIMEOUT_CYCLES - 1)) begin
          state_n = IDLE;
          timeout = 1'b1;
        end
`endif
      end
      RECV:  if (cnt == RECV_LAST) state_n = DONE;
      DONE:  state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  assign bus.busy        = (state != IDLE);
  assign bus.done        = (state == DONE);
  assign bus.mm_start    = (state == START);
  assign bus.mm_valid    = (state == SEND);
  assign bus.mm_data_out = (state == SEND) ? op_sel : '0;

  // One counter serves both phases; it parks at the phase's last index.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else begin
      case (state)
        SEND:    if (cnt != SEND_LAST) cnt <= cnt + 5'd1;
        RECV:    if (cnt != RECV_LAST) cnt <= cnt + 5'd1;
        default: cnt <= '0;
      endcase
    end
  end

  always_comb begin
    op_sel = '0;
    for (int unsigned i = 0; i < 18; i++)
      if (cnt == 5'(i)) op_sel = operand[i];
  end

  assign rx_idx  = 4'(cnt / 5'd3);
  assign rx_slot = 2'(cnt % 5'd3);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < 18; i++) operand[i] <= '0;
    end else if (state == IDLE && bus.wr_en && !bus.go) begin
      for (int unsigned i = 0; i < 18; i++)
        if (bus.wr_addr == 5'(i)) operand[i] <= bus.wr_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < 9; i++) result[i] <= '0;
    end else if (state == RECV) begin
      for (int unsigned i = 0; i < 9; i++) begin
        if (rx_idx == 4'(i)) begin
          case (rx_slot)
            2'd0:    result[i][7:0]   <= bus.mm_data_in;
            2'd1:    result[i][15:8]  <= bus.mm_data_in;
            default: result[i][17:16] <= bus.mm_data_in[1:0];
          endcase
        end
      end
    end
  end

  always_comb begin
    bus.rd_data = '0;
    for (int unsigned i = 0; i < 9; i++)
      if (bus.rd_addr == 4'(i)) bus.rd_data = result[i];
  end

`ifdef MMH_TIMEOUT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                 to_cnt <= '0;
    else if (state == WAIT)  to_cnt <= to_cnt + 1'b1;
    else                     to_cnt <= '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                         err_q <= 1'b0;
    else if (state == IDLE && bus.go) err_q <= 1'b0;
    else if (timeout)                err_q <= 1'b1;
  end

  assign bus.err = err_q;
`else
  assign bus.err = 1'b0;
`endif

endmodule
